exe_stage: RTL and testbench

Execute stage of the five-stage in-order CPU. It accepts one decoded instruction per handshake from the decode stage and drives the combinational ALU. It adds a HI/LO register pair, a single-cycle multiplier and an iterative 32-step divider, detects arithmetic overflow exceptions, and hands the result to the memory stage through a valid/allowin handshake.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/exe_stage_div_iter.sv | 98 +++++++++
 rtl/exe_stage.sv | 140 ++++++++++++++
 tb/tb_exe_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: one-hot operation bit positions, exception codes,
// the execute-stage latch layout and a small magnitude helper.
package cpu_pkg;

  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_AND  = 9;
  localparam int ALU_OR   = 8;
  localparam int ALU_NOR  = 7;
  localparam int ALU_XOR  = 6;
  localparam int ALU_SLT  = 5;
  localparam int ALU_SLTU = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam int MD_MULT  = 3;
  localparam int MD_MULTU = 2;
  localparam int MD_DIV   = 1;
  localparam int MD_DIVU  = 0;

  localparam int HL_MFHI  = 3;
  localparam int HL_MFLO  = 2;
  localparam int HL_MTHI  = 1;
  localparam int HL_MTLO  = 0;

  localparam logic [4:0] EXCODE_OV = 5'h0c;

  typedef struct packed {
    logic [31:0] pc;
    logic [11:0] aluop;
    logic [31:0] src0;
    logic [31:0] src1;
    logic [3:0]  mdop;
    logic [3:0]  hilo_op;
    logic        ov_en;
    logic [4:0]  dest;
    logic        rf_we;
  } es_fields_t;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/exe_stage_div_iter.sv
// Iterative restoring divider: loads on start, then produces one quotient bit
// per cycle for 32 cycles; done holds until the next start or a kill.
module div_iter
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        kill,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [32:0] shifted, diff;

  // next-state: load, abort, or one restoring step
  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    if (start) begin
      cnt_d   = 5'd0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      rem_d   = 32'd0;
      quo_d   = abs32(a, sgn);
      dvs_d   = abs32(b, sgn);
      q_neg_d = sgn & (a[31] ^ b[31]);
      r_neg_d = sgn & a[31];
    end else if (kill) begin
      cnt_d  = 5'd0;
      busy_d = 1'b0;
      done_d = 1'b0;
    end else if (busy_q) begin
      // borrow out of the trial subtraction means restore
      if (diff[32]) begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end else begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
        done_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end

  assign done      = done_q;
  assign quotient  = q_neg_q ? (32'd0 - quo_q) : quo_q;
  assign remainder = r_neg_q ? (32'd0 - rem_q) : rem_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches decoded instructions, feeds the ALU, owns HI/LO with
// a single-cycle multiplier and an iterative divider, and flags overflow.
module exe_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [31:0] ds_pc,
  input  logic [11:0] ds_aluop,
  input  logic [31:0] ds_src0,
  input  logic [31:0] ds_src1,
  input  logic [3:0]  ds_mdop,
  input  logic [3:0]  ds_hilo_op,
  input  logic        ds_ov_en,
  input  logic [4:0]  ds_dest,
  input  logic        ds_rf_we,
  output logic [31:0] alu_src0,
  output logic [31:0] alu_src1,
  output logic [11:0] alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic        es_to_ms_valid,
  input  logic        ms_allowin,
  output logic [31:0] es_pc,
  output logic [31:0] es_result,
  output logic [4:0]  es_dest,
  output logic        es_rf_we,
  output logic        es_ex,
  output logic [4:0]  es_excode
);

  logic        es_valid_q, es_valid_d;
  es_fields_t  fs_q, fs_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        md_is_div, md_is_mul, es_ready_go, capture, leave, fire;
  logic        div_start, div_kill, div_done;
  logic [31:0] div_quo, div_rem;
  logic [63:0] mul_a, mul_b, mul_prod;

  assign md_is_div   = fs_q.mdop[MD_DIV] | fs_q.mdop[MD_DIVU];
  assign md_is_mul   = fs_q.mdop[MD_MULT] | fs_q.mdop[MD_MULTU];
  assign es_ready_go = !(md_is_div && !div_done);
  assign es_allowin  = !es_valid_q || (es_ready_go && ms_allowin);
  assign capture     = ds_to_es_valid && es_allowin && !flush;
  assign leave       = es_valid_q && es_ready_go && ms_allowin;
  assign fire        = leave && !es_ex && !flush;

  // the divider starts on the capture edge so it finishes 32 cycles later
  assign div_start = capture && (ds_mdop[MD_DIV] | ds_mdop[MD_DIVU]);
  assign div_kill  = flush || leave;

  div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .kill      (div_kill),
    .sgn       (ds_mdop[MD_DIV]),
    .a         (ds_src0),
    .b         (ds_src1),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign mul_a    = fs_q.mdop[MD_MULT] ? {{32{fs_q.src0[31]}}, fs_q.src0} : {32'd0, fs_q.src0};
  assign mul_b    = fs_q.mdop[MD_MULT] ? {{32{fs_q.src1[31]}}, fs_q.src1} : {32'd0, fs_q.src1};
  assign mul_prod = mul_a * mul_b;

  // pipeline valid and instruction latch
  always_comb begin
    fs_d       = fs_q;
    es_valid_d = es_valid_q;
    if (flush) begin
      es_valid_d = 1'b0;
    end else if (capture) begin
      es_valid_d = 1'b1;
      fs_d = '{pc: ds_pc, aluop: ds_aluop, src0: ds_src0, src1: ds_src1,
               mdop: ds_mdop, hilo_op: ds_hilo_op, ov_en: ds_ov_en,
               dest: ds_dest, rf_we: ds_rf_we};
    end else if (es_allowin) begin
      es_valid_d = 1'b0;
    end else begin
      es_valid_d = es_valid_q;
    end
  end

  // HI/LO commit on the edge the instruction leaves
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (fire) begin
      if (md_is_mul) begin
        {hi_d, lo_d} = mul_prod;
      end else if (md_is_div) begin
        lo_d = div_quo;
        hi_d = div_rem;
      end else if (fs_q.hilo_op[HL_MTHI]) begin
        hi_d = fs_q.src0;
      end else if (fs_q.hilo_op[HL_MTLO]) begin
        lo_d = fs_q.src0;
      end else begin
        hi_d = hi_q;
      end
    end else begin
      hi_d = hi_q;
    end
  end

  // stage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      fs_q       <= '0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      es_valid_q <= es_valid_d;
      fs_q       <= fs_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign alu_src0       = fs_q.src0;
  assign alu_src1       = fs_q.src1;
  assign alu_op         = fs_q.aluop;
  assign es_to_ms_valid = es_valid_q && es_ready_go && !flush;
  assign es_pc          = fs_q.pc;
  assign es_dest        = fs_q.dest;
  assign es_ex          = es_valid_q && fs_q.ov_en && alu_overflow;
  assign es_excode      = es_ex ? EXCODE_OV : 5'd0;
  assign es_rf_we       = es_valid_q && fs_q.rf_we && !es_ex;
  assign es_result      = !es_valid_q             ? 32'd0 :
                          fs_q.hilo_op[HL_MFHI]   ? hi_q  :
                          fs_q.hilo_op[HL_MFLO]   ? lo_q  : alu_result;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: a small ALU model closes the loop, and each
// vector is checked against hand-computed values.
module tb_exe_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, ds_to_es_valid, es_allowin;
  logic [31:0] ds_pc, ds_src0, ds_src1;
  logic [11:0] ds_aluop;
  logic [3:0]  ds_mdop, ds_hilo_op;
  logic        ds_ov_en, ds_rf_we;
  logic [4:0]  ds_dest;
  logic [31:0] alu_src0, alu_src1, alu_result;
  logic [11:0] alu_op;
  logic        alu_overflow;
  logic        es_to_ms_valid, ms_allowin;
  logic [31:0] es_pc, es_result;
  logic [4:0]  es_dest, es_excode;
  logic        es_rf_we, es_ex;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [11:0] OP_ADD = 12'b1 << ALU_ADD;
  localparam logic [11:0] OP_OR  = 12'b1 << ALU_OR;
  localparam logic [3:0]  M_MULT  = 4'b1 << MD_MULT;
  localparam logic [3:0]  M_MULTU = 4'b1 << MD_MULTU;
  localparam logic [3:0]  M_DIV   = 4'b1 << MD_DIV;
  localparam logic [3:0]  M_DIVU  = 4'b1 << MD_DIVU;
  localparam logic [3:0]  H_MFHI  = 4'b1 << HL_MFHI;
  localparam logic [3:0]  H_MFLO  = 4'b1 << HL_MFLO;

  exe_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_pc(ds_pc), .ds_aluop(ds_aluop), .ds_src0(ds_src0), .ds_src1(ds_src1),
    .ds_mdop(ds_mdop), .ds_hilo_op(ds_hilo_op), .ds_ov_en(ds_ov_en),
    .ds_dest(ds_dest), .ds_rf_we(ds_rf_we),
    .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_result(es_result), .es_dest(es_dest),
    .es_rf_we(es_rf_we), .es_ex(es_ex), .es_excode(es_excode)
  );

  always #5 clk = ~clk;

  // minimal ALU: add and or are all the vectors need
  always_comb begin
    alu_result   = 32'd0;
    alu_overflow = 1'b0;
    if (alu_op[ALU_ADD]) begin
      alu_result   = alu_src0 + alu_src1;
      alu_overflow = (alu_src0[31] == alu_src1[31]) && (alu_result[31] != alu_src0[31]);
    end else if (alu_op[ALU_OR]) begin
      alu_result = alu_src0 | alu_src1;
    end else begin
      alu_result = 32'd0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [11:0] op, input logic [31:0] s0,
                       input logic [31:0] s1, input logic [3:0] md, input logic [3:0] hl,
                       input logic ov, input logic [4:0] dst, input logic we);
    ds_pc = pc; ds_aluop = op; ds_src0 = s0; ds_src1 = s1; ds_mdop = md;
    ds_hilo_op = hl; ds_ov_en = ov; ds_dest = dst; ds_rf_we = we;
    ds_to_es_valid = 1'b1;
    tick();
    ds_to_es_valid = 1'b0;
    #1;
  endtask

  task automatic drain();
    ms_allowin = 1'b1;
    tick();
    tick();
    #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (es_to_ms_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    issue(32'h900, 12'd0, 32'd0, 32'd0, 4'd0, H_MFHI, 1'b0, 5'd2, 1'b1);
    check({tag, "_hi"}, es_result, hi);
    issue(32'h904, 12'd0, 32'd0, 32'd0, 4'd0, H_MFLO, 1'b0, 5'd3, 1'b1);
    check({tag, "_lo"}, es_result, lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bad;
    reset = 1'b1; flush = 1'b0; ds_to_es_valid = 1'b0; ms_allowin = 1'b1;
    ds_pc = 32'd0; ds_aluop = 12'd0; ds_src0 = 32'd0; ds_src1 = 32'd0;
    ds_mdop = 4'd0; ds_hilo_op = 4'd0; ds_ov_en = 1'b0; ds_dest = 5'd0; ds_rf_we = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_allowin", es_allowin, 1);
    check("rst_to_ms", es_to_ms_valid, 0);
    check("rst_result", es_result, 0);
    check("rst_pc", es_pc, 0);
    check("rst_rf_we", es_rf_we, 0);
    check("rst_excode", es_excode, 0);

    // overflowing add traps, addu does not
    issue(32'h100, OP_ADD, 32'h7FFFFFFF, 32'd1, 4'd0, 4'd0, 1'b1, 5'd4, 1'b1);
    check("add_ex", es_ex, 1);
    check("add_excode", es_excode, 5'h0c);
    check("add_rf_we", es_rf_we, 0);
    issue(32'h104, OP_ADD, 32'h7FFFFFFF, 32'd1, 4'd0, 4'd0, 1'b0, 5'd4, 1'b1);
    check("addu_result", es_result, 32'h80000000);
    check("addu_rf_we", es_rf_we, 1);
    check("addu_ex", es_ex, 0);
    check("addu_pc", es_pc, 32'h104);

    issue(32'h108, 12'd0, 32'hFFFFFFFE, 32'd3, M_MULT, 4'd0, 1'b0, 5'd0, 1'b0);
    read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
    issue(32'h10c, 12'd0, 32'hFFFFFFFE, 32'd3, M_MULTU, 4'd0, 1'b0, 5'd0, 1'b0);
    read_hilo("multu", 32'h2, 32'hFFFFFFFA);

    // div -7/2 with cycle-by-cycle stall check
    drain();
    issue(32'h200, 12'd0, 32'hFFFFFFF9, 32'd2, M_DIV, 4'd0, 1'b0, 5'd0, 1'b0);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (es_allowin !== 1'b0 || es_to_ms_valid !== 1'b0) bad++;
      tick();
    end
    check("div_stall_cycles", bad, 0);
    check("div_c33_to_ms", es_to_ms_valid, 1);
    check("div_c33_allowin", es_allowin, 1);
    read_hilo("div_neg7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);

    drain();
    issue(32'h210, 12'd0, 32'h80000000, 32'hFFFFFFFF, M_DIV, 4'd0, 1'b0, 5'd0, 1'b0);
    wait_out(lat);
    check("div_min_lat", lat, 33);
    read_hilo("div_min", 32'h0, 32'h80000000);

    drain();
    issue(32'h220, 12'd0, 32'h80000000, 32'hFFFFFFFF, M_DIVU, 4'd0, 1'b0, 5'd0, 1'b0);
    wait_out(lat);
    check("divu_lat", lat, 33);
    read_hilo("divu", 32'h80000000, 32'h0);

    // back-pressure with a second instruction waiting
    drain();
    ms_allowin = 1'b0;
    issue(32'h300, OP_OR, 32'h0000F0F0, 32'h00000F0F, 4'd0, 4'd0, 1'b0, 5'd7, 1'b1);
    check("bp_result", es_result, 32'h0000FFFF);
    check("bp_allowin", es_allowin, 0);
    ds_pc = 32'h304; ds_aluop = OP_ADD; ds_src0 = 32'd1; ds_src1 = 32'd2;
    ds_mdop = 4'd0; ds_hilo_op = 4'd0; ds_ov_en = 1'b0; ds_dest = 5'd8; ds_rf_we = 1'b1;
    ds_to_es_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (es_pc !== 32'h300 || es_result !== 32'h0000FFFF || es_dest !== 5'd7 ||
          es_allowin !== 1'b0 || es_to_ms_valid !== 1'b1 || es_rf_we !== 1'b1) bad++;
    end
    check("bp_stable", bad, 0);
    ms_allowin = 1'b1;
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    check("bp_next_pc", es_pc, 32'h304);
    check("bp_next_result", es_result, 32'd3);
    check("bp_next_dest", es_dest, 8);

    // flush in cycle 10 of a divide leaves HI/LO alone
    drain();
    issue(32'h400, 12'd0, 32'd100, 32'd7, M_DIV, 4'd0, 1'b0, 5'd0, 1'b0);
    for (int k = 2; k <= 10; k++) tick();
    flush = 1'b1;
    #1;
    check("flush_to_ms", es_to_ms_valid, 0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_allowin", es_allowin, 1);
    check("flush_result", es_result, 0);
    read_hilo("flush_hilo", 32'h80000000, 32'h0);
    drain();
    issue(32'h410, 12'd0, 32'd100, 32'd7, M_DIVU, 4'd0, 1'b0, 5'd0, 1'b0);
    wait_out(lat);
    check("post_flush_lat", lat, 33);
    read_hilo("divu_100_7", 32'd2, 32'd14);

    // reset in the middle of a divide
    drain();
    issue(32'h500, 12'd0, 32'd50, 32'd3, M_DIVU, 4'd0, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_allowin", es_allowin, 1);
    check("mid_rst_to_ms", es_to_ms_valid, 0);
    read_hilo("mid_rst_hilo", 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
